bpu_btb: RTL and testbench

Parametrised branch prediction unit for the five-stage RV32 pipeline: a direct-mapped branch target buffer with 2-bit saturating counters. It is looked up with the IF-stage PC to supply a predicted next PC. It is trained by the control-transfer instruction resolving in EX, and reports mispredictions and the redirect PC used to flush IF/ID and ID/EX. It replaces the fixed "predict not-taken, flush on taken" scheme with learned prediction.

---
 rtl/bpu_btb_if.sv | 30 +++
 rtl/bpu_btb.sv | 123 ++++++++++++
 tb/tb_bpu_btb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_btb_if.sv
// Fetch/execute bundle between the pipeline and the branch target buffer.
// The pipeline side is the master; the BTB is the slave.
interface bpu_btb_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid;
    logic              ex_is_branch;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit saturating counters, looked up from IF and trained from EX.
// Optional performance counters are enabled by defining BPU_PERF_EN.
module bpu_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    bpu_btb_if.slave    btb_io
`ifdef BPU_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts,
    output logic [31:0] perf_taken_preds
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int TGT_W = ADDR_W - 2;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TGT_W-1:0] tgt_q   [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             pred_taken;
    logic             mispredict;

    assign if_idx = btb_io.if_pc[IDX_W+1:2];
    assign if_tag = btb_io.if_pc[ADDR_W-1:IDX_W+2];
    assign ex_idx = btb_io.ex_pc[IDX_W+1:2];
    assign ex_tag = btb_io.ex_pc[ADDR_W-1:IDX_W+2];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign pred_taken         = if_hit & cnt_q[if_idx][1];
    assign btb_io.pred_taken  = pred_taken;
    assign btb_io.pred_target = pred_taken ? {tgt_q[if_idx], 2'b00}
                                           : btb_io.if_pc + ADDR_W'(4);

    assign mispredict = btb_io.ex_valid &
                        ((btb_io.ex_taken != btb_io.ex_pred_taken) |
                         (btb_io.ex_taken & (btb_io.ex_target != btb_io.ex_pred_target)));
    assign btb_io.mispredict  = mispredict;
    assign btb_io.redirect_pc = (btb_io.ex_valid & btb_io.ex_taken) ? btb_io.ex_target
                                                                    : btb_io.ex_pc + ADDR_W'(4);

    logic             ent_we;
    logic             ent_valid_d;
    logic [TAG_W-1:0] ent_tag_d;
    logic [TGT_W-1:0] ent_tgt_d;
    logic [1:0]       ent_cnt_d;

    // Next contents of the entry addressed by ex_pc; a not-taken miss leaves the table alone.
    always_comb begin
        ent_we      = 1'b0;
        ent_valid_d = valid_q[ex_idx];
        ent_tag_d   = tag_q[ex_idx];
        ent_tgt_d   = tgt_q[ex_idx];
        ent_cnt_d   = cnt_q[ex_idx];
        if (btb_io.ex_valid) begin
            if (ex_hit) begin
                ent_we = 1'b1;
                if (btb_io.ex_is_branch) begin
                    if (btb_io.ex_taken) begin
                        ent_tgt_d = btb_io.ex_target[ADDR_W-1:2];
                        if (cnt_q[ex_idx] != 2'b11) ent_cnt_d = cnt_q[ex_idx] + 2'd1;
                    end else if (cnt_q[ex_idx] != 2'b00) begin
                        ent_cnt_d = cnt_q[ex_idx] - 2'd1;
                    end
                end else begin
                    ent_cnt_d = 2'b11;
                    ent_tgt_d = btb_io.ex_target[ADDR_W-1:2];
                end
            end else if (btb_io.ex_taken) begin
                ent_we      = 1'b1;
                ent_valid_d = 1'b1;
                ent_tag_d   = ex_tag;
                ent_tgt_d   = btb_io.ex_target[ADDR_W-1:2];
                ent_cnt_d   = btb_io.ex_is_branch ? 2'b10 : 2'b11;
            end
        end
    end

    // Tag and target need no reset: they are only consulted behind a set valid bit.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (ent_we) begin
            valid_q[ex_idx] <= ent_valid_d;
            tag_q[ex_idx]   <= ent_tag_d;
            tgt_q[ex_idx]   <= ent_tgt_d;
            cnt_q[ex_idx]   <= ent_cnt_d;
        end
    end

`ifdef BPU_PERF_EN
    logic [31:0] perf_br_q, perf_mis_q, perf_tp_q;

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
            perf_tp_q  <= '0;
        end else begin
            perf_br_q  <= perf_br_q  + 32'(btb_io.ex_valid);
            perf_mis_q <= perf_mis_q + 32'(mispredict);
            perf_tp_q  <= perf_tp_q  + 32'(pred_taken);
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
    assign perf_taken_preds = perf_tp_q;
`endif
endmodule

// File: tb/tb_bpu_btb.sv
// Directed and random checks of bpu_btb against a behavioural table model.
// Define BPU_PERF_EN to also check the performance counters.
module tb_bpu_btb;
    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bpu_btb_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef BPU_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts, perf_taken_preds;
`endif

    bpu_btb #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) dut (
        .cpu_clk  (clk),
        .cpu_rstn (rstn),
        .btb_io   (bus)
`ifdef BPU_PERF_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts),
        .perf_taken_preds (perf_taken_preds)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference table: one slot per index, counter kept as a plain integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
`ifdef BPU_PERF_EN
    int unsigned p_br, p_mis, p_tp;
`endif

    logic        obs_pt, obs_mis;
    logic [31:0] obs_ptgt, obs_red;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
        int          idx = int'((pc >> 2) % ENTRIES);
        int unsigned tag = pc / (4 * ENTRIES);
        pt  = m_valid[idx] && (m_tag[idx] == tag) && (m_cnt[idx] >= 2);
        tgt = pt ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void m_update(input logic r, input logic exv, input logic isbr,
                                     input logic [31:0] expc, input logic taken,
                                     input logic [31:0] extgt);
        int          idx = int'((expc >> 2) % ENTRIES);
        int unsigned tag = expc / (4 * ENTRIES);
        if (!r) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_cnt[i]   = 1;
            end
            return;
        end
        if (!exv) return;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (isbr) begin
                if (taken) begin
                    m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
                    m_tgt[idx] = extgt & ~32'd3;
                end else begin
                    m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
                end
            end else begin
                m_cnt[idx] = 3;
                m_tgt[idx] = extgt & ~32'd3;
            end
        end else if (taken) begin
            m_valid[idx] = 1;
            m_tag[idx]   = tag;
            m_tgt[idx]   = extgt & ~32'd3;
            m_cnt[idx]   = isbr ? 2 : 3;
        end
    endfunction

    // Drive one cycle of inputs, check all outputs mid-cycle, then advance model and DUT.
    task automatic cycle(input logic r, input logic [31:0] ifpc, input logic exv, input logic isbr,
                         input logic [31:0] expc, input logic taken, input logic [31:0] extgt,
                         input logic ptk, input logic [31:0] ptgt);
        logic        e_pt, e_mis;
        logic [31:0] e_ptgt, e_red;
        rstn               = r;
        bus.if_pc          = ifpc;
        bus.ex_valid       = exv;
        bus.ex_is_branch   = isbr;
        bus.ex_pc          = expc;
        bus.ex_taken       = taken;
        bus.ex_target      = extgt;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptgt;
        #1;
        m_lookup(ifpc, e_pt, e_ptgt);
        e_mis = exv && ((taken != ptk) || (taken && (extgt != ptgt)));
        e_red = (exv && taken) ? extgt : expc + 32'd4;
        obs_pt   = bus.pred_taken;
        obs_ptgt = bus.pred_target;
        obs_mis  = bus.mispredict;
        obs_red  = bus.redirect_pc;
        check("pred_taken",  obs_pt,   e_pt);
        check("pred_target", obs_ptgt, e_ptgt);
        check("mispredict",  obs_mis,  e_mis);
        check("redirect_pc", obs_red,  e_red);
`ifdef BPU_PERF_EN
        check("perf_branches",    perf_branches,    p_br);
        check("perf_mispredicts", perf_mispredicts, p_mis);
        check("perf_taken_preds", perf_taken_preds, p_tp);
`endif
        @(posedge clk);
        m_update(r, exv, isbr, expc, taken, extgt);
`ifdef BPU_PERF_EN
        if (!r) begin
            p_br = 0; p_mis = 0; p_tp = 0;
        end else begin
            p_br  += 32'(exv);
            p_mis += 32'(e_mis);
            p_tp  += 32'(e_pt);
        end
`endif
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] ifpc);
        cycle(1'b1, ifpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Conditional branch resolving at pc, carrying the model's own prediction down the pipe.
    task automatic br(input logic [31:0] ifpc, input logic [31:0] pc, input logic taken,
                      input logic [31:0] tgt);
        logic        ptk;
        logic [31:0] ptgt;
        m_lookup(pc, ptk, ptgt);
        cycle(1'b1, ifpc, 1'b1, 1'b1, pc, taken, tgt, ptk, ptgt);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tag;
        tag = ($urandom_range(0, 7) == 0) ? 32'h03FF_FFFF : 32'($urandom_range(0, 2));
        return (tag << 6) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
    endfunction

    initial begin
        logic        r, exv, isbr, taken, ptk;
        logic [31:0] ifpc, expc, tgt, ptgt;

        m_update(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef BPU_PERF_EN
        p_br = 0; p_mis = 0; p_tp = 0;
`endif
        bus.if_pc = '0; bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0; bus.ex_pc = '0;
        bus.ex_taken = 1'b0; bus.ex_target = '0; bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        idle(32'h100);
        check("rst_pt",   obs_pt,   1'b0);
        check("rst_ptgt", obs_ptgt, 32'h104);
        check("rst_mis",  obs_mis,  1'b0);

        cycle(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h180, 1'b0, 32'h204);
        check("train_mis", obs_mis, 1'b1);
        check("train_red", obs_red, 32'h180);
        idle(32'h200);
        check("learned_pt",   obs_pt,   1'b1);
        check("learned_ptgt", obs_ptgt, 32'h180);

        br(32'h200, 32'h200, 1'b0, 32'h0);
        br(32'h200, 32'h200, 1'b1, 32'h180);
        check("hyst_nt_pt", obs_pt, 1'b0);
        br(32'h200, 32'h200, 1'b1, 32'h180);
        br(32'h200, 32'h200, 1'b0, 32'h0);
        check("hyst_sat_pt", obs_pt, 1'b1);
        idle(32'h200);
        check("hyst_stay_pt", obs_pt, 1'b1);
        repeat (4) br(32'h200, 32'h200, 1'b0, 32'h0);
        br(32'h200, 32'h200, 1'b1, 32'h180);
        idle(32'h200);
        check("no_underflow_pt", obs_pt, 1'b0);
        br(32'h0, 32'h200, 1'b1, 32'h180);
        idle(32'h200);
        check("retrain_pt", obs_pt, 1'b1);

        idle(32'h240);
        check("alias_miss_pt",   obs_pt,   1'b0);
        check("alias_miss_ptgt", obs_ptgt, 32'h244);
        cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h240, 1'b1, 32'h400, 1'b0, 32'h244);
        idle(32'h240);
        check("alias_new_pt",   obs_pt,   1'b1);
        check("alias_new_ptgt", obs_ptgt, 32'h400);
        idle(32'h200);
        check("alias_evict_pt", obs_pt, 1'b0);

        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b0, 32'h0);
        check("wrap_ptgt", obs_ptgt, 32'h0);
        check("wrap_red",  obs_red,  32'h0);

        cycle(1'b1, 32'h300, 1'b1, 1'b1, 32'h300, 1'b1, 32'h80, 1'b0, 32'h304);
        check("same_cycle_pt", obs_pt, 1'b0);
        idle(32'h300);
        check("same_next_pt",   obs_pt,   1'b1);
        check("same_next_ptgt", obs_ptgt, 32'h80);

        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h340, 1'b1, 32'h500, 1'b0, 32'h0);
        idle(32'h340);
        check("rst_upd_pt",   obs_pt,   1'b0);
        check("rst_upd_ptgt", obs_ptgt, 32'h344);
`ifdef BPU_PERF_EN
        check("perf_rst_br",  perf_branches,    32'd0);
        check("perf_rst_mis", perf_mispredicts, 32'd0);
        check("perf_rst_tp",  perf_taken_preds, 32'd0);
`endif
        idle(32'h300);
        check("rst_clear_pt", obs_pt, 1'b0);

        cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600);
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h504, 1'b0, 32'h0,   1'b0, 32'h508);
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h508, 1'b1, 32'h700, 1'b0, 32'h50C);
        idle(32'h0);
`ifdef BPU_PERF_EN
        check("perf_br3",  perf_branches,    32'd3);
        check("perf_mis1", perf_mispredicts, 32'd1);
`endif

        for (int n = 0; n < 400; n++) begin
            r     = ($urandom_range(0, 63) != 0);
            ifpc  = rand_pc();
            exv   = 1'($urandom_range(0, 1));
            expc  = rand_pc();
            isbr  = ($urandom_range(0, 3) != 0);
            taken = isbr ? 1'($urandom_range(0, 1)) : 1'b1;
            tgt   = rand_pc() | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            if ($urandom_range(0, 3) != 0) m_lookup(expc, ptk, ptgt);
            else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = rand_pc();
            end
            cycle(r, ifpc, exv, isbr, expc, taken, tgt, ptk, ptgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
